sdes_stream_ctrl: RTL and testbench

// Byte-stream front end for the registered S-DES encrypt/decrypt core. Accepts plaintext

---
 rtl/sdes_stream_ctrl.sv | 119 +++++++++++
 tb/tb_sdes_stream_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdes_stream_ctrl.sv
// Byte-stream front end for a registered S-DES core with a fixed 2-cycle latency.
// Input FIFO -> credit-gated issue -> 2-stage tag pipe -> output FIFO, plus decrypt self-check.
module sdes_stream_ctrl #(
  parameter int IN_DEPTH  = 4,
  parameter int OUT_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        in_valid_i,
  input  logic [7:0]  in_data_i,
  output logic        in_ready_o,
  output logic        out_valid_o,
  output logic [7:0]  out_data_o,
  input  logic        out_ready_i,
  output logic        core_rst_n_o,
  output logic [7:0]  core_pt_o,
  input  logic [7:0]  core_ct_i,
  input  logic [7:0]  core_dt_i,
  output logic        err_flag_o,
  output logic [7:0]  err_count_o,
  output logic [15:0] blk_count_o
);
  localparam int IAW = $clog2(IN_DEPTH);
  localparam int OAW = $clog2(OUT_DEPTH);

  logic [7:0]     in_mem_q [IN_DEPTH];
  logic [IAW-1:0] in_wp_q, in_wp_d, in_rp_q, in_rp_d;
  logic [IAW:0]   in_cnt_q, in_cnt_d;
  logic [7:0]     out_mem_q [OUT_DEPTH];
  logic [OAW-1:0] out_wp_q, out_wp_d, out_rp_q, out_rp_d;
  logic [OAW:0]   out_cnt_q, out_cnt_d;
  logic [1:0]     v_q, v_d;
  logic [7:0]     ptag0_q, ptag0_d, ptag1_q, ptag1_d;
  logic [7:0]     core_pt_q;
  logic           core_rst_n_q;
  logic           err_flag_q, err_flag_d;
  logic [7:0]     err_cnt_q, err_cnt_d;
  logic [15:0]    blk_cnt_q, blk_cnt_d;

  logic           in_push, in_empty, issue, out_push, out_pop, mismatch;
  logic [7:0]     in_head;
  logic [OAW+1:0] credit;

  assign in_empty    = (in_cnt_q == '0);
  assign in_ready_o  = (in_cnt_q != (IAW+1)'(IN_DEPTH)) && core_rst_n_q && !reset_i;
  assign in_push     = in_valid_i && in_ready_o;
  assign in_head     = in_mem_q[in_rp_q];

  // Occupied plus already-reserved output slots; an issue only goes out if its slot is free.
  assign credit = {1'b0, out_cnt_q} + {{(OAW+1){1'b0}}, v_q[0]} + {{(OAW+1){1'b0}}, v_q[1]};
  assign issue  = !in_empty && (credit < (OAW+2)'(OUT_DEPTH)) && core_rst_n_q;

  assign core_pt_o    = issue ? in_head : core_pt_q;
  assign core_rst_n_o = core_rst_n_q;

  assign out_push    = v_q[1];
  assign out_valid_o = (out_cnt_q != '0) && !reset_i;
  assign out_pop     = out_valid_o && out_ready_i;
  assign out_data_o  = out_mem_q[out_rp_q];
  assign mismatch    = v_q[1] && (core_dt_i != ptag1_q);

  assign err_flag_o  = err_flag_q;
  assign err_count_o = err_cnt_q;
  assign blk_count_o = blk_cnt_q;

  always_comb begin
    in_wp_d   = in_push ? in_wp_q + IAW'(1) : in_wp_q;
    in_rp_d   = issue ? in_rp_q + IAW'(1) : in_rp_q;
    in_cnt_d  = in_cnt_q + (IAW+1)'(in_push) - (IAW+1)'(issue);
    out_wp_d  = out_push ? out_wp_q + OAW'(1) : out_wp_q;
    out_rp_d  = out_pop ? out_rp_q + OAW'(1) : out_rp_q;
    out_cnt_d = out_cnt_q + (OAW+1)'(out_push) - (OAW+1)'(out_pop);
    v_d       = {v_q[0], issue};
    ptag0_d   = issue ? in_head : ptag0_q;
    ptag1_d   = ptag0_q;
    err_flag_d = err_flag_q | mismatch;
    err_cnt_d  = (mismatch && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
    blk_cnt_d  = blk_cnt_q + 16'(out_pop);
  end

  always_ff @(posedge clk_i) begin
    if (in_push) in_mem_q[in_wp_q] <= in_data_i;
    if (out_push) out_mem_q[out_wp_q] <= core_ct_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      in_wp_q      <= '0;
      in_rp_q      <= '0;
      in_cnt_q     <= '0;
      out_wp_q     <= '0;
      out_rp_q     <= '0;
      out_cnt_q    <= '0;
      v_q          <= '0;
      ptag0_q      <= '0;
      ptag1_q      <= '0;
      core_pt_q    <= '0;
      core_rst_n_q <= 1'b0;
      err_flag_q   <= 1'b0;
      err_cnt_q    <= '0;
      blk_cnt_q    <= '0;
    end else begin
      in_wp_q      <= in_wp_d;
      in_rp_q      <= in_rp_d;
      in_cnt_q     <= in_cnt_d;
      out_wp_q     <= out_wp_d;
      out_rp_q     <= out_rp_d;
      out_cnt_q    <= out_cnt_d;
      v_q          <= v_d;
      ptag0_q      <= ptag0_d;
      ptag1_q      <= ptag1_d;
      core_pt_q    <= core_pt_o;
      core_rst_n_q <= 1'b1;
      err_flag_q   <= err_flag_d;
      err_cnt_q    <= err_cnt_d;
      blk_cnt_q    <= blk_cnt_d;
    end
  end
endmodule

// File: tb/tb_sdes_stream_ctrl.sv
// Bench for sdes_stream_ctrl with a behavioural 2-cycle S-DES core and fault-injection hooks.
`timescale 1ns/1ps
module tb_sdes_stream_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, in_valid, out_ready;
  logic [7:0]  in_data;
  logic        in_ready, out_valid, core_rst_n, err_flag;
  logic [7:0]  out_data, core_pt, core_ct, core_dt, err_count;
  logic [15:0] blk_count;

  sdes_stream_ctrl #(.IN_DEPTH(4), .OUT_DEPTH(4)) dut (
    .clk_i(clk), .reset_i(reset), .in_valid_i(in_valid), .in_data_i(in_data),
    .in_ready_o(in_ready), .out_valid_o(out_valid), .out_data_o(out_data),
    .out_ready_i(out_ready), .core_rst_n_o(core_rst_n), .core_pt_o(core_pt),
    .core_ct_i(core_ct), .core_dt_i(core_dt), .err_flag_o(err_flag),
    .err_count_o(err_count), .blk_count_o(blk_count)
  );

  localparam int P10_T[10] = '{3, 5, 2, 7, 4, 10, 1, 9, 8, 6};
  localparam int P8_T[8]   = '{6, 3, 7, 4, 8, 5, 10, 9};
  localparam int IP_T[8]   = '{2, 6, 3, 1, 4, 8, 5, 7};
  localparam int EP_T[8]   = '{4, 1, 2, 3, 2, 3, 4, 1};
  localparam int P4_T[4]   = '{2, 4, 3, 1};
  localparam logic [1:0] S0_T[16] = '{2'd1, 2'd0, 2'd3, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0,
                                      2'd0, 2'd2, 2'd1, 2'd3, 2'd3, 2'd1, 2'd3, 2'd2};
  localparam logic [1:0] S1_T[16] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd0, 2'd1, 2'd3,
                                      2'd3, 2'd0, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0, 2'd3};
  localparam logic [9:0] KEY = 10'b1010000010;

  function automatic logic [7:0] ip_f(input logic [7:0] x);
    logic [7:0] y = '0;
    for (int i = 0; i < 8; i++) y[7-i] = x[8-IP_T[i]];
    return y;
  endfunction

  function automatic logic [7:0] ipinv_f(input logic [7:0] x);
    logic [7:0] y = '0;
    for (int i = 0; i < 8; i++) y[8-IP_T[i]] = x[7-i];
    return y;
  endfunction

  function automatic logic [4:0] rol5(input logic [4:0] h, input int s);
    return (s == 1) ? {h[3:0], h[4]} : {h[2:0], h[4:3]};
  endfunction

  function automatic logic [7:0] subkey(input int n);
    logic [9:0] p = '0;
    logic [9:0] lr;
    logic [7:0] k = '0;
    logic [4:0] l, r;
    for (int i = 0; i < 10; i++) p[9-i] = KEY[10-P10_T[i]];
    l = rol5(p[9:5], 1);
    r = rol5(p[4:0], 1);
    if (n == 2) begin
      l = rol5(l, 2);
      r = rol5(r, 2);
    end
    lr = {l, r};
    for (int i = 0; i < 8; i++) k[7-i] = lr[10-P8_T[i]];
    return k;
  endfunction

  function automatic logic [7:0] fk(input logic [7:0] x, input logic [7:0] k);
    logic [7:0] e = '0;
    logic [7:0] t;
    logic [3:0] s, p;
    p = '0;
    for (int i = 0; i < 8; i++) e[7-i] = x[4-EP_T[i]];
    t = e ^ k;
    s[3:2] = S0_T[{t[7], t[4], t[6], t[5]}];
    s[1:0] = S1_T[{t[3], t[0], t[2], t[1]}];
    for (int i = 0; i < 4; i++) p[3-i] = s[4-P4_T[i]];
    return {x[7:4] ^ p, x[3:0]};
  endfunction

  function automatic logic [7:0] sdes_enc(input logic [7:0] pt);
    logic [7:0] y;
    y = fk(ip_f(pt), subkey(1));
    y = fk({y[3:0], y[7:4]}, subkey(2));
    return ipinv_f(y);
  endfunction

  function automatic logic [7:0] sdes_dec(input logic [7:0] ct);
    logic [7:0] y;
    y = fk(ip_f(ct), subkey(2));
    y = fk({y[3:0], y[7:4]}, subkey(1));
    return ipinv_f(y);
  endfunction

  // Behavioural core: stage 1 latches core_pt, stage 2 presents ct/dt.
  logic       corrupt_all, corrupt_one;
  logic [7:0] corrupt_pt, core_r1;
  always @(posedge clk) begin
    if (!core_rst_n) begin
      core_r1 <= '0;
      core_ct <= '0;
      core_dt <= '0;
    end else begin
      core_r1 <= core_pt;
      core_ct <= sdes_enc(core_r1);
      core_dt <= sdes_dec(sdes_enc(core_r1)) ^
                 {7'd0, corrupt_all || (corrupt_one && core_r1 == corrupt_pt)};
    end
  end

  int         cyc, pop_cnt;
  logic       rec_en;
  logic [7:0] outq[$];
  int         outcyc[$];
  logic       outerr[$];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (out_valid && out_ready) begin
      pop_cnt <= pop_cnt + 1;
      if (rec_en) begin
        outq.push_back(out_data);
        outcyc.push_back(cyc);
        outerr.push_back(err_flag);
      end
    end
  end

  int n_tests, n_fail;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_n(input logic [7:0] start, input int n, input int budget,
                        output int acc, output logic dropped);
    logic ok;
    acc = 0;
    dropped = 1'b0;
    for (int c = 0; c < budget && acc < n; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = start + 8'(acc);
      ok = in_ready;
      if (!ok && acc > 0) dropped = 1'b1;
      @(posedge clk);
      if (ok) acc++;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_pops(input int target, input int budget, input string name);
    int c = 0;
    while (pop_cnt < target && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk({name, " drained"}, 32'(pop_cnt >= target), 1);
  endtask

  typedef struct {
    logic [7:0]  pt;
    logic [7:0]  exp_ct;
    logic [15:0] exp_blk;
  } vec_t;

  initial begin
    vec_t       vecs[6];
    logic [7:0] pts[6];
    int         acc, base, p0, lat, gaps;
    logic       drop;
    logic [7:0] got;

    pts = '{8'h97, 8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h3C};
    for (int i = 0; i < 6; i++) begin
      vecs[i].pt      = pts[i];
      vecs[i].exp_ct  = sdes_enc(pts[i]);
      vecs[i].exp_blk = 16'(i + 1);
    end

    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    corrupt_all = 1'b0; corrupt_one = 1'b0; corrupt_pt = '0; rec_en = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst in_ready", in_ready, 0);
    chk("rst out_valid", out_valid, 0);
    chk("rst core_rst_n", core_rst_n, 0);
    chk("rst core_pt", core_pt, 0);
    chk("rst err_flag", err_flag, 0);
    chk("rst err_count", err_count, 0);
    chk("rst blk_count", blk_count, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("post-rst in_ready", in_ready, 1);
    chk("post-rst core_rst_n", core_rst_n, 1);
    chk("post-rst out_valid", out_valid, 0);

    // Single-byte transactions: latency, ciphertext, error flag, block count.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = vecs[i].pt;
      chk("vec in_ready", in_ready, 1);
      @(posedge clk);
      lat = 0;
      got = '0;
      for (int k = 1; k <= 10; k++) begin
        @(negedge clk);
        if (k == 1) in_valid = 1'b0;
        if (out_valid) begin
          lat = k;
          got = out_data;
          break;
        end
      end
      chk("vec latency", lat, 4);
      chk("vec ct", got, vecs[i].exp_ct);
      @(negedge clk);
      chk("vec err_flag", err_flag, 0);
      chk("vec blk_count", blk_count, vecs[i].exp_blk);
    end

    // Back-to-back stream of 16 bytes.
    base = outq.size();
    p0 = pop_cnt;
    send_n(8'h00, 16, 40, acc, drop);
    wait_pops(p0 + 16, 50, "t2");
    repeat (6) @(negedge clk);
    chk("t2 accepted", acc, 16);
    chk("t2 in_ready drop", drop, 0);
    chk("t2 count", pop_cnt - p0, 16);
    gaps = 0;
    for (int i = 0; i < 16; i++) begin
      chk("t2 data", outq[base+i], sdes_enc(8'(i)));
      if (i > 0 && outcyc[base+i] - outcyc[base+i-1] != 1) gaps++;
    end
    chk("t2 gaps", gaps, 0);

    // Backpressure: 12 bytes with out_ready low.
    out_ready = 1'b0;
    base = outq.size();
    p0 = pop_cnt;
    send_n(8'h20, 12, 20, acc, drop);
    chk("t3 accepted while stalled", acc, 8);
    chk("t3 in_ready full", in_ready, 0);
    chk("t3 out_valid", out_valid, 1);
    repeat (5) @(negedge clk);
    chk("t3 head stable", out_data, sdes_enc(8'h20));
    chk("t3 in_ready still full", in_ready, 0);
    out_ready = 1'b1;
    send_n(8'h28, 4, 40, acc, drop);
    chk("t3 rest accepted", acc, 4);
    wait_pops(p0 + 12, 50, "t3");
    repeat (8) @(negedge clk);
    chk("t3 count", pop_cnt - p0, 12);
    for (int i = 0; i < 12; i++) chk("t3 data", outq[base+i], sdes_enc(8'h20 + 8'(i)));

    // Corrupted decrypt on the third byte only.
    corrupt_one = 1'b1;
    corrupt_pt  = 8'h32;
    base = outq.size();
    p0 = pop_cnt;
    send_n(8'h30, 5, 20, acc, drop);
    wait_pops(p0 + 5, 50, "t4");
    repeat (4) @(negedge clk);
    corrupt_one = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t4 data", outq[base+i], sdes_enc(8'h30 + 8'(i)));
      chk("t4 err at pop", outerr[base+i], 32'(i >= 2));
    end
    chk("t4 err_flag", err_flag, 1);
    chk("t4 err_count", err_count, 1);

    // Reset with 3 bytes buffered and 2 in flight.
    out_ready = 1'b0;
    send_n(8'h40, 12, 20, acc, drop);
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'h48; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("t5 out_valid in reset", out_valid, 0);
    chk("t5 in_ready in reset", in_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("t5 out_valid after", out_valid, 0);
    chk("t5 err_count", err_count, 0);
    chk("t5 err_flag", err_flag, 0);
    chk("t5 blk_count", blk_count, 0);
    @(negedge clk);
    chk("t5 in_ready back", in_ready, 1);
    out_ready = 1'b1;
    base = outq.size();
    p0 = pop_cnt;
    send_n(8'h5A, 1, 5, acc, drop);
    repeat (12) @(negedge clk);
    chk("t5 single output", pop_cnt - p0, 1);
    chk("t5 data", outq[base], sdes_enc(8'h5A));
    chk("t5 blk_count one", blk_count, 1);

    // Saturation and wrap.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    rec_en = 1'b0;
    corrupt_all = 1'b1;
    p0 = pop_cnt;
    send_n(8'h00, 254, 400, acc, drop);
    wait_pops(p0 + 254, 50, "t6a");
    chk("t6 err_count 254", err_count, 8'hFE);
    send_n(8'h00, 1, 10, acc, drop);
    wait_pops(p0 + 255, 50, "t6b");
    chk("t6 err_count 255", err_count, 8'hFF);
    send_n(8'h00, 45, 100, acc, drop);
    wait_pops(p0 + 300, 50, "t6c");
    chk("t6 err_count sat", err_count, 8'hFF);
    chk("t6 err_flag", err_flag, 1);
    corrupt_all = 1'b0;
    send_n(8'h00, 65235, 65400, acc, drop);
    wait_pops(p0 + 65535, 50, "t6d");
    chk("t6 blk_count ffff", blk_count, 16'hFFFF);
    send_n(8'h00, 2, 10, acc, drop);
    wait_pops(p0 + 65537, 50, "t6e");
    chk("t6 blk_count wrap", blk_count, 16'h0001);
    chk("t6 err_count held", err_count, 8'hFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
